// File: rtl/mod_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mod_addsub : R = (A +/- B) mod M using two passes through one mpadder.   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+

module mpadder (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic          subtract,
   input  logic [1026:0] in_a,
   input  logic [1026:0] in_b,
   output logic [1027:0] result,
   output logic          done
);
   localparam int c_LO_W = 514;
   localparam int c_HI_W = 1028 - c_LO_W;

   logic [1027:0]     w_xa;
   logic [1027:0]     w_xb;
   logic [c_LO_W:0]   w_lo_sum;
   logic [c_HI_W-1:0] w_hi_sum;

   logic              r_busy;
   logic              r_carry;
   logic [c_LO_W-1:0] r_lo;
   logic [c_HI_W-1:0] r_xa_hi;
   logic [c_HI_W-1:0] r_xb_hi;

   // Subtraction is A + ~B + 1 over 1028 bits, so bit 1027 ends up as the borrow.
   assign w_xa     = {1'b0, in_a};
   assign w_xb     = subtract ? ~{1'b0, in_b} : {1'b0, in_b};
   assign w_lo_sum = {1'b0, w_xa[c_LO_W-1:0]} + {1'b0, w_xb[c_LO_W-1:0]}
                   + {{c_LO_W{1'b0}}, subtract};
   assign w_hi_sum = r_xa_hi + r_xb_hi + {{(c_HI_W-1){1'b0}}, r_carry};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_busy  <= 1'b0;
         r_carry <= 1'b0;
         r_lo    <= '0;
         r_xa_hi <= '0;
         r_xb_hi <= '0;
         result  <= '0;
         done    <= 1'b0;
      end else begin
         r_busy <= start;
         done   <= r_busy;
         if (start) begin
            r_lo    <= w_lo_sum[c_LO_W-1:0];
            r_carry <= w_lo_sum[c_LO_W];
            r_xa_hi <= w_xa[1027:c_LO_W];
            r_xb_hi <= w_xb[1027:c_LO_W];
         end
         if (r_busy) begin
            result <= {w_hi_sum, r_lo};
         end
      end
   end
endmodule

module mod_addsub (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic          subtract,
   input  logic [1026:0] in_a,
   input  logic [1026:0] in_b,
   input  logic [1026:0] in_m,
   output logic [1026:0] result,
   output logic          done
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_OP1   = 3'd1,
      S_WAIT1 = 3'd2,
      S_OP2   = 3'd3,
      S_WAIT2 = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next_state;

   logic [1026:0] r_a;
   logic [1026:0] r_b;
   logic [1026:0] r_m;
   logic          r_op;
   logic [1027:0] r_s;

   logic          w_add_start;
   logic          w_add_sub;
   logic [1026:0] w_add_a;
   logic [1026:0] w_add_b;
   logic [1027:0] w_add_result;
   logic          w_add_done;
   logic [1026:0] w_final;

   mpadder u_adder (
      .clk      (clk),
      .resetn   (resetn),
      .start    (w_add_start),
      .subtract (w_add_sub),
      .in_a     (w_add_a),
      .in_b     (w_add_b),
      .result   (w_add_result),
      .done     (w_add_done)
   );

   always_comb begin
      w_next_state = r_state;
      w_add_start  = 1'b0;
      w_add_a      = r_a;
      w_add_b      = r_b;
      w_add_sub    = r_op;
      // The correction operands stay on the adder for the whole second pass.
      if (r_state == S_OP2 || r_state == S_WAIT2) begin
         w_add_a   = r_s[1026:0];
         w_add_b   = r_m;
         w_add_sub = ~r_op;
      end
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_OP1;
         S_OP1: begin
            w_add_start  = 1'b1;
            w_next_state = S_WAIT1;
         end
         S_WAIT1: if (w_add_done) w_next_state = S_OP2;
         S_OP2: begin
            w_add_start  = 1'b1;
            w_next_state = S_WAIT2;
         end
         S_WAIT2: if (w_add_done) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Add keeps S unless S-M is non-negative; subtract takes S+M only when A-B borrowed.
   assign w_final = r_op ? (r_s[1027]          ? w_add_result[1026:0] : r_s[1026:0])
                         : (w_add_result[1027] ? r_s[1026:0]          : w_add_result[1026:0]);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_m     <= '0;
         r_op    <= 1'b0;
         r_s     <= '0;
         result  <= '0;
         done    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         done    <= 1'b0;
         if (r_state == S_IDLE && start) begin
            r_a  <= in_a;
            r_b  <= in_b;
            r_m  <= in_m;
            r_op <= subtract;
         end
         if (r_state == S_WAIT1 && w_add_done) begin
            r_s <= w_add_result;
         end
         if (r_state == S_WAIT2 && w_add_done) begin
            result <= w_final;
            done   <= 1'b1;
         end
      end
   end
endmodule

`default_nettype wire
